onehot_encoder_stream: RTL and testbench
========================================

Name: onehot_encoder_stream

Overview:
Multi-lane, handshaked successor to the combinational one-hot encoder. Each cycle it encodes NumLanes packed indices into one-hot, thermometer or inverted one-hot vectors. Results pass through a 2-entry output buffer with valid/ready flow control. It sits between the systolic-array index producers, such as PE-select and row-enable logic, and their consumers.

Parameters:
DWidth, 4, index width per lane
OWidth, 2**DWidth, encoded vector width per lane; must be <= 2**DWidth (indices >= OWidth are out-of-range)
NumLanes, 4, number of parallel lanes; lane 0 occupies the least-significant slice

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
valid_i  input  1  input beat valid
ready_o  output  1  block can accept a beat
data_i  input  NumLanes*DWidth  packed lane indices
lane_en_i  input  NumLanes  per-lane enable, sampled with the beat
mode_i  input  2  encoding mode, sampled with the beat
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts the beat
data_o  output  NumLanes*OWidth  packed encoded vectors
oor_o  output  NumLanes  per-lane out-of-range flag
beat_cnt_o  output  32  count of output handshakes

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high.
  - The reset edge empties the buffer and clears beat_cnt_o.
  - Values after reset: valid_o=0, ready_o=1, data_o=0, oor_o=0, beat_cnt_o=0.
  - While rst=1, inputs are ignored and no beat is captured.
- Reset mid-operation: buffered beats are discarded, not drained. Post-reset values apply at the next cycle.
- Modes:
  - 2'b00 ONEHOT: bit idx set.
  - 2'b01 THERMO: bits [idx:0] set.
  - 2'b10 INV_ONEHOT: all bits set except idx.
  - 2'b11 reserved: lane vector all zeros, oor cleared.
- Lane rules:
  - lane_en_i[k]=0: vector k = 0 and oor[k]=0, regardless of index or mode.
  - Enabled lane with idx >= OWidth: vector k = 0 and oor[k]=1, in any non-reserved mode.
- Encoding is combinational on the input side. The encoded vector and oor are written into the buffer; mode and data are not re-evaluated later.
- Buffer: 2 entries, occupancy count 0..2.
  - Push when valid_i && ready_o; pop when valid_o && ready_i.
  - ready_o = (count != 2), decoded from the registered count only. No combinational path from ready_i to ready_o.
  - valid_o = (count != 0).
  - data_o/oor_o show the head entry, forced to 0 when count = 0.
  - Push and pop in the same cycle leave count unchanged; the new entry queues behind the head. Output order equals acceptance order.
- Latency and throughput:
  - 1 cycle from the accept edge to valid_o.
  - Full throughput (1 beat/cycle) when ready_i is held high.
- Backpressure:
  - With ready_i=0, two beats are accepted; ready_o then drops the cycle after the second accept.
  - valid_o, data_o and oor_o are held stable until the handshake.
- Counter: beat_cnt_o increments by 1 per output handshake and wraps 2^32-1 -> 0.

Decomposition:
- Package onehot_pkg:
  - enc_mode_e enum: ENC_ONEHOT=2'b00, ENC_THERMO=2'b01, ENC_INV_ONEHOT=2'b10, ENC_RSVD=2'b11.
  - localparam BufDepth=2.
  - localparam CntWidth=32.
- Sub-module onehot_lane_enc (combinational; params DWidth and OWidth; inputs idx, en, mode; outputs vec, oor). Instantiated NumLanes times via generate.
- Buffer, counter and handshake logic stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_i=1 -> valid_o=0, ready_o=1, beat_cnt_o=0; no beat appears after rst drops.
- ONEHOT with defaults, lanes 0..3 = {7,15,0,3}, all enabled, ready_i=1 -> next cycle valid_o=1, lane vectors 0x0080, 0x8000, 0x0001, 0x0008, beat_cnt_o 0 -> 1.
- Mode sweep:
  - THERMO idx {0,15,5,2} -> 0x0001, 0xFFFF, 0x003F, 0x0007.
  - INV_ONEHOT idx 3 -> 0xFFF7.
  - Mode 2'b11 -> all-zero vectors, oor_o=0.
- Backpressure: ready_i=0, offer 3 consecutive beats A,B,C -> A and B accepted, ready_o=0 while C is held. Raise ready_i -> A, B, C emerge in order, beat_cnt_o=3.
- OWidth=10 instance:
  - Enabled lane idx 12 -> vector 0, oor=1.
  - Disabled lane idx 12 -> vector 0, oor=0.
  - Enabled lane idx 9 ONEHOT -> 0x200.
- Reset mid-operation: buffer full (count 2), ready_i=0, assert rst one cycle -> next cycle valid_o=0, ready_o=1, beat_cnt_o=0; neither buffered beat is ever output.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared types and constants for the streaming one-hot encoder.
package onehot_pkg;

  typedef enum logic [1:0] {
    ENC_ONEHOT     = 2'b00,
    ENC_THERMO     = 2'b01,
    ENC_INV_ONEHOT = 2'b10,
    ENC_RSVD       = 2'b11
  } enc_mode_e;

  localparam int unsigned BufDepth = 2;
  localparam int unsigned CntWidth = 32;

endpackage

// File: rtl/onehot_encoder_stream_lane_enc.sv
// Single-lane combinational encoder: index -> one-hot / thermometer / inverted one-hot.
module onehot_lane_enc
  import onehot_pkg::*;
#(
  parameter int unsigned DWidth = 4,
  parameter int unsigned OWidth = 2 ** DWidth
) (
  input  logic [DWidth-1:0] idx,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [OWidth-1:0] vec,
  output logic              oor
);

  // One extra bit so OWidth == 2**DWidth is representable in the range compare.
  localparam int unsigned IdxW = DWidth + 1;

  logic [IdxW-1:0] idx_ext;
  enc_mode_e       mode_e;

  assign idx_ext = {1'b0, idx};
  assign mode_e  = enc_mode_e'(mode);

  // Encode the index; disabled lanes, reserved mode and out-of-range indices give a zero vector.
  always_comb begin
    vec = '0;
    oor = 1'b0;
    if (en && (mode_e != ENC_RSVD)) begin
      if (idx_ext >= IdxW'(OWidth)) begin
        oor = 1'b1;
      end else begin
        for (int unsigned i = 0; i < OWidth; i++) begin
          case (mode_e)
            ENC_ONEHOT:     vec[i] = (IdxW'(i) == idx_ext);
            ENC_THERMO:     vec[i] = (IdxW'(i) <= idx_ext);
            ENC_INV_ONEHOT: vec[i] = (IdxW'(i) != idx_ext);
            default:        vec[i] = 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/onehot_encoder_stream.sv
// Multi-lane index encoder with a 2-entry valid/ready output buffer and beat counter.
module onehot_encoder_stream
  import onehot_pkg::*;
#(
  parameter int unsigned DWidth   = 4,
  parameter int unsigned OWidth   = 2 ** DWidth,
  parameter int unsigned NumLanes = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [NumLanes*DWidth-1:0]   data_i,
  input  logic [NumLanes-1:0]          lane_en_i,
  input  logic [1:0]                   mode_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NumLanes*OWidth-1:0]   data_o,
  output logic [NumLanes-1:0]          oor_o,
  output logic [CntWidth-1:0]          beat_cnt_o
);

  localparam int unsigned DataW  = NumLanes * OWidth;
  localparam int unsigned CountW = $clog2(BufDepth + 1);
  localparam int unsigned PtrW   = $clog2(BufDepth);

  logic [DataW-1:0]    enc_data;
  logic [NumLanes-1:0] enc_oor;

  logic [DataW-1:0]    slot_data [BufDepth];
  logic [NumLanes-1:0] slot_oor  [BufDepth];
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [CountW-1:0]   count;

  logic push;
  logic pop;

  // Per-lane encoders; lane 0 sits in the least-significant slice.
  for (genvar g = 0; g < NumLanes; g++) begin : g_lane
    onehot_lane_enc #(
      .DWidth(DWidth),
      .OWidth(OWidth)
    ) u_lane (
      .idx (data_i[g*DWidth +: DWidth]),
      .en  (lane_en_i[g]),
      .mode(mode_i),
      .vec (enc_data[g*OWidth +: OWidth]),
      .oor (enc_oor[g])
    );
  end

  // Handshake decode; ready depends only on the registered occupancy.
  assign ready_o = (count != CountW'(BufDepth));
  assign valid_o = (count != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // Head entry is presented, zeroed while the buffer is empty.
  assign data_o = valid_o ? slot_data[rd_ptr] : '0;
  assign oor_o  = valid_o ? slot_oor[rd_ptr]  : '0;

  // Buffer storage: written on push only, no reset needed since reads are masked by count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      slot_data[wr_ptr] <= enc_data;
      slot_oor[wr_ptr]  <= enc_oor;
    end
  end

  // Pointers, occupancy and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PtrW'(1);
        beat_cnt_o <= beat_cnt_o + CntWidth'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Self-checking bench for onehot_encoder_stream against a queue-based reference model.
module tb_onehot_encoder_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i;
  logic [15:0] data_i;
  logic [3:0]  lane_en_i;
  logic [1:0]  mode_i;
  logic        ready_o, valid_o;
  logic [63:0] data_o;
  logic [3:0]  oor_o;
  logic [31:0] beat_cnt_o;

  logic        v10_i, r10_i, r10_o, v10_o;
  logic [15:0] d10_i;
  logic [3:0]  en10_i, oor10_o;
  logic [1:0]  m10_i;
  logic [39:0] d10_o;
  logic [31:0] cnt10_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] q_data[$];
  logic [3:0]  q_oor[$];
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  onehot_encoder_stream dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .lane_en_i(lane_en_i), .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .oor_o(oor_o), .beat_cnt_o(beat_cnt_o)
  );

  onehot_encoder_stream #(.DWidth(4), .OWidth(10), .NumLanes(4)) dut10 (
    .clk(clk), .rst(rst), .valid_i(v10_i), .ready_o(r10_o), .data_i(d10_i),
    .lane_en_i(en10_i), .mode_i(m10_i), .valid_o(v10_o), .ready_i(r10_i),
    .data_o(d10_o), .oor_o(oor10_o), .beat_cnt_o(cnt10_o)
  );

  // Reference encoding of one lane, from the mode definitions.
  function automatic int unsigned lane_vec(int unsigned idx, bit en, int unsigned m, int unsigned ow);
    int unsigned full;
    full = (32'd1 << ow) - 32'd1;
    if (!en || m == 3 || idx >= ow) return 0;
    case (m)
      0:       return 32'd1 << idx;
      1:       return (32'd2 << idx) - 32'd1;
      default: return full & ~(32'd1 << idx);
    endcase
  endfunction

  function automatic bit lane_oor(int unsigned idx, bit en, int unsigned m, int unsigned ow);
    return en && (m != 3) && (idx >= ow);
  endfunction

  function automatic logic [63:0] ref_data(logic [15:0] d, logic [3:0] en, logic [1:0] m);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = 16'(lane_vec(int'(d[4*k +: 4]), en[k], int'(m), 16));
    return r;
  endfunction

  function automatic logic [3:0] ref_oor(logic [15:0] d, logic [3:0] en, logic [1:0] m, int unsigned ow);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = lane_oor(int'(d[4*k +: 4]), en[k], int'(m), ow);
    return r;
  endfunction

  function automatic logic [39:0] ref_data10(logic [15:0] d, logic [3:0] en, logic [1:0] m);
    logic [39:0] r;
    for (int k = 0; k < 4; k++) r[10*k +: 10] = 10'(lane_vec(int'(d[4*k +: 4]), en[k], int'(m), 10));
    return r;
  endfunction

  // Advance one clock and update the model with the handshakes the current inputs imply.
  task automatic cycle();
    bit push, pop;
    logic [63:0] nd;
    logic [3:0]  no;
    push = valid_i && !rst && (q_data.size() < 2);
    pop  = ready_i && !rst && (q_data.size() > 0);
    nd   = ref_data(data_i, lane_en_i, mode_i);
    no   = ref_oor(data_i, lane_en_i, mode_i, 16);
    @(negedge clk);
    if (rst) begin
      q_data.delete();
      q_oor.delete();
      exp_cnt = '0;
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_oor.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
      if (push) begin
        q_data.push_back(nd);
        q_oor.push_back(no);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 16'h1234; lane_en_i = 4'hF; mode_i = 2'b00;
    cycle();
    cycle();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (beat_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", beat_cnt_o); end
    checks++; if (data_o !== 64'd0 || oor_o !== 4'd0) begin errors++; $display("FAIL reset_data got=%h/%b exp=0/0", data_o, oor_o); end
    rst = 1'b0; valid_i = 1'b0;
    cycle();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_no_beat got=%b exp=0", valid_o); end
  endtask

  task automatic test_onehot();
    valid_i = 1'b1; ready_i = 1'b1; data_i = 16'h30F7; lane_en_i = 4'hF; mode_i = 2'b00;
    cycle();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL onehot_valid got=%b exp=1", valid_o); end
    checks++; if (data_o !== 64'h0008_0001_8000_0080) begin errors++; $display("FAIL onehot_data got=%h exp=%h", data_o, 64'h0008_0001_8000_0080); end
    checks++; if (beat_cnt_o !== 32'd0) begin errors++; $display("FAIL onehot_cnt0 got=%0d exp=0", beat_cnt_o); end
    cycle();
    checks++; if (beat_cnt_o !== 32'd1) begin errors++; $display("FAIL onehot_cnt1 got=%0d exp=1", beat_cnt_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL onehot_drained got=%b exp=0", valid_o); end
  endtask

  task automatic test_modes();
    logic [15:0] td [3] = '{16'h25F0, 16'h3333, 16'h7A3C};
    logic [1:0]  tm [3] = '{2'b01, 2'b10, 2'b11};
    logic [63:0] te [3] = '{64'h0007_003F_FFFF_0001, 64'hFFF7_FFF7_FFF7_FFF7, 64'h0};
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; ready_i = 1'b1; data_i = td[i]; lane_en_i = 4'hF; mode_i = tm[i];
      cycle();
      valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1 || data_o !== te[i]) begin errors++; $display("FAIL mode%0d_data got=%b/%h exp=1/%h", tm[i], valid_o, data_o, te[i]); end
      checks++; if (oor_o !== 4'd0) begin errors++; $display("FAIL mode%0d_oor got=%b exp=0", tm[i], oor_o); end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] bd [3];
    logic [1:0]  bm [3];
    logic [63:0] be [3];
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bd[i] = 16'($urandom); bm[i] = 2'($urandom_range(0, 2));
      be[i] = ref_data(bd[i], 4'hF, bm[i]);
    end
    lane_en_i = 4'hF;
    valid_i = 1'b1; data_i = bd[0]; mode_i = bm[0];
    cycle();
    checks++; if (ready_o !== 1'b1 || data_o !== be[0]) begin errors++; $display("FAIL bp_a got=%b/%h exp=1/%h", ready_o, data_o, be[0]); end
    data_i = bd[1]; mode_i = bm[1];
    cycle();
    checks++; if (ready_o !== 1'b0 || data_o !== be[0]) begin errors++; $display("FAIL bp_full got=%b/%h exp=0/%h", ready_o, data_o, be[0]); end
    data_i = bd[2]; mode_i = bm[2];
    cycle();
    checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== be[0]) begin errors++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/%h", ready_o, valid_o, data_o, be[0]); end
    ready_i = 1'b1;
    cycle();
    checks++; if (data_o !== be[1]) begin errors++; $display("FAIL bp_b got=%h exp=%h", data_o, be[1]); end
    cycle();
    checks++; if (data_o !== be[2]) begin errors++; $display("FAIL bp_c got=%h exp=%h", data_o, be[2]); end
    valid_i = 1'b0;
    cycle();
    checks++; if (beat_cnt_o !== 32'd3 || valid_o !== 1'b0) begin errors++; $display("FAIL bp_cnt got=%0d/%b exp=3/0", beat_cnt_o, valid_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      valid_i = 1'($urandom); ready_i = ($urandom_range(0, 3) != 0);
      data_i = 16'($urandom); lane_en_i = 4'($urandom); mode_i = 2'($urandom);
      cycle();
      checks++; if (valid_o !== (q_data.size() != 0) || ready_o !== (q_data.size() != 2)) begin
        errors++; $display("FAIL rand_flags n=%0d got=%b/%b exp_occ=%0d", n, valid_o, ready_o, q_data.size());
      end
      checks++; if (beat_cnt_o !== exp_cnt) begin errors++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, beat_cnt_o, exp_cnt); end
      if (q_data.size() != 0) begin
        checks++; if (data_o !== q_data[0] || oor_o !== q_oor[0]) begin
          errors++; $display("FAIL rand_data n=%0d got=%h/%b exp=%h/%b", n, data_o, oor_o, q_data[0], q_oor[0]);
        end
      end else begin
        checks++; if (data_o !== 64'd0 || oor_o !== 4'd0) begin errors++; $display("FAIL rand_empty n=%0d got=%h/%b exp=0/0", n, data_o, oor_o); end
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_owidth10();
    logic [39:0] ed;
    logic [3:0]  eo;
    r10_i = 1'b1; v10_i = 1'b1; d10_i = 16'h09CC; en10_i = 4'b1101; m10_i = 2'b00;
    @(negedge clk);
    checks++; if (v10_o !== 1'b1 || d10_o !== {10'h001, 10'h200, 10'h000, 10'h000}) begin
      errors++; $display("FAIL ow10_data got=%b/%h exp=1/%h", v10_o, d10_o, {10'h001, 10'h200, 10'h000, 10'h000});
    end
    checks++; if (oor10_o !== 4'b0001) begin errors++; $display("FAIL ow10_oor got=%b exp=0001", oor10_o); end
    for (int n = 0; n < 40; n++) begin
      d10_i = 16'($urandom); en10_i = 4'($urandom); m10_i = 2'($urandom);
      ed = ref_data10(d10_i, en10_i, m10_i);
      eo = ref_oor(d10_i, en10_i, m10_i, 10);
      @(negedge clk);
      checks++; if (v10_o !== 1'b1 || d10_o !== ed || oor10_o !== eo) begin
        errors++; $display("FAIL ow10_rand n=%0d got=%h/%b exp=%h/%b", n, d10_o, oor10_o, ed, eo);
      end
    end
    v10_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0; valid_i = 1'b1; lane_en_i = 4'hF; mode_i = 2'b00; data_i = 16'h4321;
    cycle();
    data_i = 16'h8765;
    cycle();
    checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin errors++; $display("FAIL rmid_full got=%b/%b exp=0/1", ready_o, valid_o); end
    rst = 1'b1;
    cycle();
    rst = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || beat_cnt_o !== 32'd0) begin
      errors++; $display("FAIL rmid_post got=%b/%b/%0d exp=0/1/0", valid_o, ready_o, beat_cnt_o);
    end
    ready_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++; if (valid_o !== 1'b0 || beat_cnt_o !== 32'd0) begin errors++; $display("FAIL rmid_drop n=%0d got=%b/%0d exp=0/0", n, valid_o, beat_cnt_o); end
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0; lane_en_i = '0; mode_i = '0;
    v10_i = 1'b0; r10_i = 1'b1; d10_i = '0; en10_i = '0; m10_i = '0;
    exp_cnt = '0;
    test_reset();
    test_onehot();
    test_modes();
    test_backpressure();
    test_random();
    test_owidth10();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
